hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the ButterFly 5-stage RV32IM pipeline. Each cycle it decides whether the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or take a bubble. It resolves load-use hazards, EX-stage control-flow redirects, data-memory wait states and a multi-cycle divide sequence in EX. It also keeps saturating performance counters for stall and flush events.

---
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline <-> hazard sequencer signal bundle
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_mem_read_i;
  logic             ex_is_div_i;
  logic             ex_redirect_i;
  logic             mem_req_i;
  logic             mem_ready_i;

  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             id_ex_stall_o;
  logic             ex_mem_stall_o;
  logic             mem_wb_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             ex_mem_flush_o;
  logic             mem_wb_flush_o;
  logic             div_start_o;
  logic             div_release_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_addr_i, ex_mem_read_i, ex_is_div_i, ex_redirect_i,
           mem_req_i, mem_ready_i,
    input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
           mem_wb_flush_o, div_start_o, div_release_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_addr_i, ex_mem_read_i, ex_is_div_i, ex_redirect_i,
           mem_req_i, mem_ready_i,
    output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
           mem_wb_flush_o, div_start_o, div_release_o, stall_cnt_o, flush_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 32
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam logic [0:0]       c_S_RUN      = 1'b0;
  localparam logic [0:0]       c_S_DIV_BUSY = 1'b1;
  localparam logic [7:0]       c_DIV_INIT   = 8'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  logic [0:0]       r_state;
  logic [7:0]       r_div_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [0:0]       w_state_nxt;
  logic [7:0]       w_div_cnt_nxt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;
  logic w_mem_wb_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;
  logic w_mem_wb_flush;
  logic w_div_start;
  logic w_div_release;
  logic w_redirect_acc;

  assign w_mem_wait = bus.mem_req_i & ~bus.mem_ready_i;

  assign w_load_use = bus.ex_mem_read_i && (bus.ex_rd_addr_i != 5'd0) &&
                      ((bus.id_uses_rs1_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                       (bus.id_uses_rs2_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  // State register and saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= c_S_RUN;
      r_div_cnt   <= 8'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (w_pc_stall && (r_stall_cnt != c_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (w_redirect_acc && (r_flush_cnt != c_CNT_MAX))
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
    end
  end

  // Next-state logic; a memory wait freezes the divide sequence in place
  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    if (w_mem_wait) begin
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
    end else if ((r_state == c_S_RUN) && bus.ex_is_div_i) begin
      if (DIV_CYCLES != 1) begin
        w_state_nxt   = c_S_DIV_BUSY;
        w_div_cnt_nxt = c_DIV_INIT;
      end
    end else if ((r_state == c_S_DIV_BUSY) && (r_div_cnt != 8'd1)) begin
      w_div_cnt_nxt = r_div_cnt - 8'd1;
    end else if (r_state == c_S_DIV_BUSY) begin
      w_state_nxt   = c_S_RUN;
      w_div_cnt_nxt = 8'd0;
    end
  end

  // Output decode in fixed priority order
  always_comb begin
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;
    w_div_start    = 1'b0;
    w_div_release  = 1'b0;
    w_redirect_acc = 1'b0;
    if (rst_i) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_mem_wait) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if ((r_state == c_S_RUN) && bus.ex_is_div_i) begin
      w_div_start = 1'b1;
      if (DIV_CYCLES == 1) begin
        // Single-cycle divider: result is ready in the start cycle
        w_div_release = 1'b1;
      end else begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_stall  = 1'b1;
        w_ex_mem_flush = 1'b1;
      end
    end else if ((r_state == c_S_DIV_BUSY) && (r_div_cnt != 8'd1)) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else if (r_state == c_S_DIV_BUSY) begin
      w_div_release = 1'b1;
    end else if (bus.ex_redirect_i) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_redirect_acc = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_stall_o     = w_pc_stall;
  assign bus.if_id_stall_o  = w_if_id_stall;
  assign bus.id_ex_stall_o  = w_id_ex_stall;
  assign bus.ex_mem_stall_o = w_ex_mem_stall;
  assign bus.mem_wb_stall_o = w_mem_wb_stall;
  assign bus.if_id_flush_o  = w_if_id_flush;
  assign bus.id_ex_flush_o  = w_id_ex_flush;
  assign bus.ex_mem_flush_o = w_ex_mem_flush;
  assign bus.mem_wb_flush_o = w_mem_wb_flush;
  assign bus.div_start_o    = w_div_start;
  assign bus.div_release_o  = w_div_release;
  assign bus.stall_cnt_o    = r_stall_cnt;
  assign bus.flush_cnt_o    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed scoreboard bench for hazard_ctrl (32- and 4-bit counters)
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_ctrl;

  // Flag vector: [10:6] stalls pc,ifid,idex,exmem,memwb  [5:2] flushes ifid..memwb  [1:0] start,release
  localparam logic [10:0] F_NONE     = {5'b00000, 4'b0000, 2'b00};
  localparam logic [10:0] F_RESET    = {5'b00000, 4'b1111, 2'b00};
  localparam logic [10:0] F_LOADUSE  = {5'b11000, 4'b0100, 2'b00};
  localparam logic [10:0] F_REDIRECT = {5'b00000, 4'b1100, 2'b00};
  localparam logic [10:0] F_DSTART   = {5'b11100, 4'b0010, 2'b10};
  localparam logic [10:0] F_DBUSY    = {5'b11100, 4'b0010, 2'b00};
  localparam logic [10:0] F_DREL     = {5'b00000, 4'b0000, 2'b01};
  localparam logic [10:0] F_MEMWAIT  = {5'b11110, 4'b0001, 2'b00};

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       div;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct packed {
    logic [10:0] flags;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [3:0]  stall_s;
    logic [3:0]  flush_s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus   ();
  hazard_ctrl_if #(.CNT_W(4))  bus_s ();

  hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(4)) dut_s (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s)
  );

  logic [10:0] w_flags;
  logic [10:0] w_flags_s;
  assign w_flags = {bus.pc_stall_o, bus.if_id_stall_o, bus.id_ex_stall_o, bus.ex_mem_stall_o,
                    bus.mem_wb_stall_o, bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o,
                    bus.mem_wb_flush_o, bus.div_start_o, bus.div_release_o};
  assign w_flags_s = {bus_s.pc_stall_o, bus_s.if_id_stall_o, bus_s.id_ex_stall_o, bus_s.ex_mem_stall_o,
                      bus_s.mem_wb_stall_o, bus_s.if_id_flush_o, bus_s.id_ex_flush_o, bus_s.ex_mem_flush_o,
                      bus_s.mem_wb_flush_o, bus_s.div_start_o, bus_s.div_release_o};

  exp_t        q[$];
  exp_t        mon_e;
  exp_t        push_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic [3:0]  m_stall_s;
  logic [3:0]  m_flush_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.mrdy = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst                 = s.rst;
    bus.id_rs1_addr_i   = s.rs1;   bus_s.id_rs1_addr_i = s.rs1;
    bus.id_rs2_addr_i   = s.rs2;   bus_s.id_rs2_addr_i = s.rs2;
    bus.id_uses_rs1_i   = s.u1;    bus_s.id_uses_rs1_i = s.u1;
    bus.id_uses_rs2_i   = s.u2;    bus_s.id_uses_rs2_i = s.u2;
    bus.ex_rd_addr_i    = s.rd;    bus_s.ex_rd_addr_i  = s.rd;
    bus.ex_mem_read_i   = s.mrd;   bus_s.ex_mem_read_i = s.mrd;
    bus.ex_is_div_i     = s.div;   bus_s.ex_is_div_i   = s.div;
    bus.ex_redirect_i   = s.redir; bus_s.ex_redirect_i = s.redir;
    bus.mem_req_i       = s.mreq;  bus_s.mem_req_i     = s.mreq;
    bus.mem_ready_i     = s.mrdy;  bus_s.mem_ready_i   = s.mrdy;
  endtask

  // Drive one cycle, queue its expectation, then advance the expected counters
  task automatic step(input stim_t s, input logic [10:0] ef);
    apply(s);
    push_e.flags   = ef;
    push_e.stall   = m_stall;
    push_e.flush   = m_flush;
    push_e.stall_s = m_stall_s;
    push_e.flush_s = m_flush_s;
    q.push_back(push_e);
    if (s.rst) begin
      m_stall = '0; m_flush = '0; m_stall_s = '0; m_flush_s = '0;
    end else begin
      if (ef[10]) begin
        m_stall++;
        if (m_stall_s != 4'hF) m_stall_s++;
      end
      if (ef[5]) begin
        m_flush++;
        if (m_flush_s != 4'hF) m_flush_s++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("flags",       32'(w_flags),           32'(mon_e.flags));
      chk("stall_cnt",   bus.stall_cnt_o,        mon_e.stall);
      chk("flush_cnt",   bus.flush_cnt_o,        mon_e.flush);
      chk("flags_s",     32'(w_flags_s),         32'(mon_e.flags));
      chk("stall_cnt_s", 32'(bus_s.stall_cnt_o), 32'(mon_e.stall_s));
      chk("flush_cnt_s", 32'(bus_s.flush_cnt_o), 32'(mon_e.flush_s));
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    @(posedge clk);
    #1;
    m_stall = '0; m_flush = '0; m_stall_s = '0; m_flush_s = '0;

    s = idle(); s.rst = 1'b1;                          step(s, F_RESET);
    s = idle();                                        step(s, F_NONE);

    // Load-use on rs2, then rs1; rd=0 and unused source must not stall
    s = idle(); s.mrd = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;  step(s, F_LOADUSE);
    s = idle(); s.mrd = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1;  step(s, F_LOADUSE);
    s = idle(); s.mrd = 1; s.rd = 0; s.rs2 = 0; s.u2 = 1;  step(s, F_NONE);
    s = idle(); s.mrd = 1; s.rd = 9; s.rs1 = 9; s.u1 = 0;  step(s, F_NONE);
    s = idle(); s.mrd = 0; s.rd = 9; s.rs1 = 9; s.u1 = 1;  step(s, F_NONE);

    // Redirect beats load-use; memory wait beats redirect
    s = idle(); s.redir = 1; s.mrd = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; step(s, F_REDIRECT);
    s = idle(); s.redir = 1; s.mreq = 1; s.mrdy = 0;   step(s, F_MEMWAIT);
    s = idle(); s.mreq = 1; s.mrdy = 1;                step(s, F_NONE);

    // Full divide, redirect ignored while busy
    for (int t = 0; t <= 32; t++) begin
      s = idle(); s.div = 1;
      if (t == 3) s.redir = 1;
      step(s, (t == 0) ? F_DSTART : ((t == 32) ? F_DREL : F_DBUSY));
    end
    s = idle();                                        step(s, F_NONE);

    // Wait during the start cycle delays the pulse; wait at T10..T12 shifts release to T35
    s = idle(); s.div = 1; s.mreq = 1; s.mrdy = 0;     step(s, F_MEMWAIT);
    for (int t = 0; t <= 35; t++) begin
      s = idle(); s.div = 1;
      if (t >= 10 && t <= 12) begin
        s.mreq = 1; s.mrdy = 0;
        step(s, F_MEMWAIT);
      end else begin
        step(s, (t == 0) ? F_DSTART : ((t == 35) ? F_DREL : F_DBUSY));
      end
    end
    s = idle();                                        step(s, F_NONE);

    // Reset mid-divide: no release afterwards
    for (int t = 0; t <= 4; t++) begin
      s = idle(); s.div = 1;
      step(s, (t == 0) ? F_DSTART : F_DBUSY);
    end
    s = idle(); s.div = 1; s.rst = 1;                  step(s, F_RESET);
    for (int t = 0; t < 34; t++) begin
      s = idle();                                      step(s, F_NONE);
    end

    // Long memory wait saturates the 4-bit counter at 15
    for (int t = 0; t < 20; t++) begin
      s = idle(); s.mreq = 1; s.mrdy = 0;              step(s, F_MEMWAIT);
    end
    s = idle();                                        step(s, F_NONE);
    s = idle();                                        step(s, F_NONE);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
